rip_id_stage: RTL and testbench
===============================

# rip_id_stage

Instruction-decode pipeline stage of the rip-cpu RV32I core. It sits between the fetch stage and the execute stage, beside the register file. It drives the register-file read addresses straight from the fetched instruction and registers the decoded instruction so it lines up with the register file's one-cycle-late read data. It holds operand values stable, with write-back updates, across downstream stalls, detects load-use hazards, and supports flush.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_valid  in  1  fetch presents an instruction
- if_pc  in  32  PC of fetched instruction
- if_instr  in  32  fetched instruction word
- if_ready  out  1  stage accepts; transfer when if_valid && if_ready
- if_rs1_num / if_rs2_num  out  5  combinational if_instr[19:15] / [24:20] to regfile
- rf_rs1 / rf_rs2  in  32  regfile registered read data (valid the cycle after address)
- ma_wen, ma_rd_num, ma_wdata  in  1/5/32  write-back port, mirrored from regfile write
- ex_ready  in  1  execute accepts ID contents this cycle
- ex_flush  in  1  taken branch/jump; kill ID contents
- id_valid  out  1  decoded instruction valid
- id_pc  out  32
- id_rd_num, id_rs1_num, id_rs2_num  out  5 each
- id_rs1, id_rs2  out  32  operand values
- id_imm  out  32  sign-extended immediate (I/S/B/U/J per opcode)
- id_alu_op  out  alu_op_e  ALU operation
- id_funct3  out  3
- id_reg_we, id_mem_re, id_mem_we, id_branch, id_jal, id_jalr, id_alu_src_imm, id_illegal  out  1 each

## Operation
- Operand FSM: EMPTY, FRESH, HELD.
  - EMPTY: nothing valid. id_valid=0.
  - FRESH: loaded on the last edge. id_rs1/id_rs2 = rf_rs1/rf_rs2.
  - HELD: stalled past the FRESH cycle. id_rs1/id_rs2 come from the hold registers.
- Load at edge (if_valid && if_ready): go to FRESH and latch pc, decoded fields and control.
- No transfer and (ex_ready or EMPTY): go to EMPTY (bubble).
- id_valid && !ex_ready: go to HELD or stay HELD. hold_rsN <= (ma_wen && ma_rd_num==id_rsN_num && id_rsN_num!=0) ? ma_wdata : id_rsN. This applies every held cycle.
- x0: id_rsN forced to 0 whenever id_rsN_num==0, regardless of rf data.
- if_ready = rst_n && !ex_flush && !load_use && (!id_valid || ex_ready).
- load_use = id_valid && id_mem_re && id_rd_num!=0 && ((uses_rs1(if_instr) && if_rs1_num==id_rd_num) || (uses_rs2(if_instr) && if_rs2_num==id_rd_num)).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH only.
  - When load_use is set and ex_ready is high, ID goes to EMPTY, which inserts one bubble. The fetch stage holds, so the regfile re-reads the same addresses.
- ex_flush: next state EMPTY, all control outputs cleared, the if-side transfer is suppressed. It takes priority over everything except reset.
- Illegal or unknown opcodes and funct combinations:
  - id_illegal=1.
  - id_reg_we, id_mem_re and id_mem_we = 0.
  - id_valid stays 1 so execute can trap.
- id_reg_we is forced to 0 when rd==0.
- Immediates are sign-extended from instr[31]. B/J immediates have bit 0 = 0; U immediates have low 12 bits = 0.

## Timing
- Reset:
  - All id_* outputs = 0, id_alu_op = ALU_ADD (0), FSM = EMPTY.
  - if_ready=0 while rst_n low and 1 on the first cycle after.
- Latency: instruction accepted at edge N gives id_valid and operands in cycle N+1. Operands are the regfile read of the same addresses at edge N.
- Reset mid-operation: the FSM returns to EMPTY on the next edge and any held operands are discarded.
- Simultaneous ex_flush and load_use: flush wins, and no bubble accounting is needed.
- Simultaneous write-back and transition FRESH to HELD: the captured value is ma_wdata, because the regfile data in the FRESH cycle predates that write.

## Configuration
- RIP_M_EXT_EN:
  - Defined: OP opcode with funct7=0000001 decodes to ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, selected by funct3.
  - Undefined: the same encodings set id_illegal=1.

## Structure
- rip_pkg holds:
  - alu_op_e enum (ALU_ADD=0 first).
  - Opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - id_state_e {EMPTY, FRESH, HELD}.
- Sub-module rip_imm_gen: combinational instr to id_imm by opcode format, instantiated on if_instr before the pipeline register.

## Test plan
- Reset, then ADDI x5,x0,7 at pc 0x0: one cycle later id_valid=1, id_imm=7, id_alu_op=ALU_ADD, id_alu_src_imm=1, id_reg_we=1, id_rs1=0.
- LW x6,0(x2) followed by ADD x7,x6,x1: if_ready=0 for one cycle, one bubble cycle (id_valid=0), then ADD issues.
- ADD x3,x1,x2 loaded, ex_ready=0 for 3 cycles, ma write x1=0xDEADBEEF in the 2nd cycle: id_rs1 becomes 0xDEADBEEF from the 3rd cycle and stays stable until accepted.
- ex_flush asserted while BEQ is valid in ID with if_valid=1: next cycle id_valid=0, all control 0, and the fetched instruction is not accepted.
- MUL x1,x2,x3 (0x023100B3): with RIP_M_EXT_EN, id_alu_op=ALU_MUL and id_illegal=0. Without it, id_illegal=1 and id_reg_we=0.
- Instruction 0xFFFFFFFF: id_illegal=1, id_mem_we=0, id_valid=1.

Source files
------------

// File: rtl/rip_pkg.sv
// rip-cpu shared decode types: ALU ops, opcodes, ID-stage state and control bundle.
// Optional M-extension decode is enabled with RIP_M_EXT_EN.
package rip_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [1:0] {EMPTY, FRESH, HELD} id_state_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_we;
    logic    mem_re;
    logic    mem_we;
    logic    branch;
    logic    jal;
    logic    jalr;
    logic    alu_src_imm;
    logic    illegal;
  } id_ctrl_t;

  function automatic logic uses_rs1(input logic [31:0] instr);
    return !(instr[6:0] == LUI || instr[6:0] == AUIPC ||
             instr[6:0] == JAL);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] instr);
    return instr[6:0] == OP || instr[6:0] == STORE ||
           instr[6:0] == BRANCH;
  endfunction

  function automatic alu_op_e alu_f3(input logic [2:0] f3,
                                     input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rip_imm_gen.sv
// rip-cpu immediate generator: sign-extended I/S/B/U/J immediate by opcode.
// Pure combinational; other opcodes yield zero.
module rip_imm_gen
  import rip_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  logic [6:0] opc;
  logic       s;

  assign opc = instr_i[6:0];
  assign s   = instr_i[31];

  always_comb begin
    imm_o = '0;
    unique case (1'b1)
      (opc == OP_IMM || opc == LOAD || opc == JALR):
        imm_o = {{20{s}}, instr_i[31:20]};
      (opc == STORE):
        imm_o = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      (opc == BRANCH):
        imm_o = {{19{s}}, s, instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      (opc == LUI || opc == AUIPC):
        imm_o = {instr_i[31:12], 12'b0};
      (opc == JAL):
        imm_o = {{11{s}}, s, instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/rip_id_stage.sv
// rip-cpu RV32I decode stage: registers decode, holds operands across stalls.
// Define RIP_M_EXT_EN to decode the M extension (otherwise illegal).
module rip_id_stage
  import rip_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            if_ready,
  output logic [4:0]      if_rs1_num,
  output logic [4:0]      if_rs2_num,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  input  logic            ma_wen,
  input  logic [4:0]      ma_rd_num,
  input  logic [XLEN-1:0] ma_wdata,
  input  logic            ex_ready,
  input  logic            ex_flush,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rd_num,
  output logic [4:0]      id_rs1_num,
  output logic [4:0]      id_rs2_num,
  output logic [XLEN-1:0] id_rs1,
  output logic [XLEN-1:0] id_rs2,
  output logic [XLEN-1:0] id_imm,
  output alu_op_e         id_alu_op,
  output logic [2:0]      id_funct3,
  output logic            id_reg_we,
  output logic            id_mem_re,
  output logic            id_mem_we,
  output logic            id_branch,
  output logic            id_jal,
  output logic            id_jalr,
  output logic            id_alu_src_imm,
  output logic            id_illegal
);

  id_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, imm_q, hold1_q, hold2_q;
  logic [4:0]      rd_q, rs1n_q, rs2n_q;
  logic [2:0]      f3_q;
  id_ctrl_t        ctrl_q, ctrl_d;
  logic [31:0]     imm_d;
  logic            load_use, xfer;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = if_instr[6:0];
  assign f3  = if_instr[14:12];
  assign f7  = if_instr[31:25];

  assign if_rs1_num = if_instr[19:15];
  assign if_rs2_num = if_instr[24:20];

  rip_imm_gen u_imm (
    .instr_i (if_instr),
    .imm_o   (imm_d)
  );

  always_comb begin
    ctrl_d = '0;
    unique case (1'b1)
      (opc == LUI): begin
        ctrl_d.reg_we = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.alu_op = ALU_LUI;
      end
      (opc == AUIPC): begin
        ctrl_d.reg_we = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
      end
      (opc == JAL): begin
        ctrl_d.reg_we = 1'b1;
        ctrl_d.jal = 1'b1;
      end
      (opc == JALR): begin
        ctrl_d.reg_we = 1'b1;
        ctrl_d.jalr = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.illegal = (f3 != 3'b000);
      end
      (opc == BRANCH): begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
        ctrl_d.illegal = (f3[2:1] == 2'b01);
      end
      (opc == LOAD): begin
        ctrl_d.reg_we = 1'b1;
        ctrl_d.mem_re = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      (opc == STORE): begin
        ctrl_d.mem_we = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.illegal = f3[2] || (f3 == 3'b011);
      end
      (opc == OP_IMM): begin
        ctrl_d.reg_we = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.alu_op = alu_f3(f3, (f3 == 3'b101) && f7[5]);
        ctrl_d.illegal =
          ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
          ((f3 == 3'b101) && (f7 != 7'b0000000) &&
           (f7 != 7'b0100000));
      end
      (opc == OP): begin
        ctrl_d.reg_we = 1'b1;
        if (f7 == 7'b0000000) begin
          ctrl_d.alu_op = alu_f3(f3, 1'b0);
        end else if (f7 == 7'b0100000 &&
                     (f3 == 3'b000 || f3 == 3'b101)) begin
          ctrl_d.alu_op = alu_f3(f3, 1'b1);
        end else if (f7 == 7'b0000001) begin
`ifdef RIP_M_EXT_EN
          ctrl_d.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(f3));
`else
          ctrl_d.illegal = 1'b1;
`endif
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    if (ctrl_d.illegal) begin
      ctrl_d.reg_we = 1'b0;
      ctrl_d.mem_re = 1'b0;
      ctrl_d.mem_we = 1'b0;
    end
    if (if_instr[11:7] == 5'd0) ctrl_d.reg_we = 1'b0;
  end

  assign id_valid = (state_q != EMPTY);

  assign load_use = id_valid && ctrl_q.mem_re && (rd_q != 5'd0) &&
    ((uses_rs1(if_instr) && if_rs1_num == rd_q) ||
     (uses_rs2(if_instr) && if_rs2_num == rd_q));

  assign if_ready = rst_n && !ex_flush && !load_use &&
                    (!id_valid || ex_ready);
  assign xfer = if_valid && if_ready;

  always_comb begin
    state_d = EMPTY;
    if (ex_flush) state_d = EMPTY;
    else if (xfer) state_d = FRESH;
    else if (id_valid && !ex_ready) state_d = HELD;
    else state_d = EMPTY;
  end

  // FRESH reads the regfile port directly; HELD uses the captured copy.
  always_comb begin
    id_rs1 = '0;
    id_rs2 = '0;
    if (rs1n_q != 5'd0) begin
      if (state_q == HELD) id_rs1 = hold1_q;
      else if (state_q == FRESH) id_rs1 = rf_rs1;
    end
    if (rs2n_q != 5'd0) begin
      if (state_q == HELD) id_rs2 = hold2_q;
      else if (state_q == FRESH) id_rs2 = rf_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pc_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rs1n_q  <= '0;
      rs2n_q  <= '0;
      f3_q    <= '0;
      ctrl_q  <= '0;
      hold1_q <= '0;
      hold2_q <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        pc_q   <= if_pc;
        imm_q  <= imm_d;
        rd_q   <= if_instr[11:7];
        rs1n_q <= if_rs1_num;
        rs2n_q <= if_rs2_num;
        f3_q   <= f3;
        ctrl_q <= ctrl_d;
      end else if (state_d != HELD) begin
        ctrl_q <= '0;
      end
      if (state_d == HELD) begin
        hold1_q <= (ma_wen && ma_rd_num == rs1n_q && rs1n_q != 5'd0)
                   ? ma_wdata : id_rs1;
        hold2_q <= (ma_wen && ma_rd_num == rs2n_q && rs2n_q != 5'd0)
                   ? ma_wdata : id_rs2;
      end
    end
  end

  assign id_pc          = pc_q;
  assign id_imm         = imm_q;
  assign id_rd_num      = rd_q;
  assign id_rs1_num     = rs1n_q;
  assign id_rs2_num     = rs2n_q;
  assign id_funct3      = f3_q;
  assign id_alu_op      = ctrl_q.alu_op;
  assign id_reg_we      = ctrl_q.reg_we;
  assign id_mem_re      = ctrl_q.mem_re;
  assign id_mem_we      = ctrl_q.mem_we;
  assign id_branch      = ctrl_q.branch;
  assign id_jal         = ctrl_q.jal;
  assign id_jalr        = ctrl_q.jalr;
  assign id_alu_src_imm = ctrl_q.alu_src_imm;
  assign id_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_rip_id_stage.sv
// Directed bench for rip_id_stage with a registered-read regfile model.
// Define RIP_M_EXT_EN for both bench and RTL to check M decode.
module tb_rip_id_stage;
  import rip_pkg::*;

  logic        clk, rst_n;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic [4:0]  if_rs1_num, if_rs2_num;
  logic [31:0] rf_rs1, rf_rs2;
  logic        ma_wen;
  logic [4:0]  ma_rd_num;
  logic [31:0] ma_wdata;
  logic        ex_ready, ex_flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1, id_rs2, id_imm;
  logic [4:0]  id_rd_num, id_rs1_num, id_rs2_num;
  alu_op_e     id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_reg_we, id_mem_re, id_mem_we, id_branch;
  logic        id_jal, id_jalr, id_alu_src_imm, id_illegal;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] regs [32];

  logic [31:0] imm_ins [4] = '{32'hFFF00093, 32'h123450B7,
                               32'hFFDFF0EF, 32'hFE20AC23};
  logic [31:0] imm_exp [4] = '{32'hFFFFFFFF, 32'h12345000,
                               32'hFFFFFFFC, 32'hFFFFFFF8};

  rip_id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready),
    .if_rs1_num(if_rs1_num), .if_rs2_num(if_rs2_num),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .ma_wen(ma_wen), .ma_rd_num(ma_rd_num), .ma_wdata(ma_wdata),
    .ex_ready(ex_ready), .ex_flush(ex_flush),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rd_num(id_rd_num), .id_rs1_num(id_rs1_num),
    .id_rs2_num(id_rs2_num),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .id_reg_we(id_reg_we), .id_mem_re(id_mem_re),
    .id_mem_we(id_mem_we), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr),
    .id_alu_src_imm(id_alu_src_imm), .id_illegal(id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile: registered read returns the pre-write value on a same-edge write.
  always @(posedge clk) begin
    rf_rs1 <= regs[if_rs1_num];
    rf_rs2 <= regs[if_rs2_num];
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + i;
    end else if (ma_wen) begin
      regs[ma_rd_num] <= ma_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0; if_valid = 0; if_pc = 0; if_instr = 0;
    ex_ready = 1; ex_flush = 0;
    ma_wen = 0; ma_rd_num = 0; ma_wdata = 0;
    tick(); tick();
    n_run++;
    if (id_valid !== 1'b0 || if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: id_valid=%b if_ready=%b want 0 0",
               id_valid, if_ready);
    end
    n_run++;
    if (id_alu_op !== ALU_ADD || id_imm !== 32'd0 ||
        id_reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: alu=%0d imm=%h we=%b want 0 0 0",
               id_alu_op, id_imm, id_reg_we);
    end
    rst_n = 1;
    #1;
    n_run++;
    if (if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: if_ready=%b want 1", if_ready);
    end
  endtask

  task automatic test_addi;
    if_valid = 1; if_instr = 32'h00700293; if_pc = 32'h0;
    tick();
    if_valid = 0;
    n_run++;
    if (id_valid !== 1 || id_imm !== 32'd7 || id_alu_op !== ALU_ADD ||
        id_alu_src_imm !== 1 || id_reg_we !== 1 || id_rs1 !== 0 ||
        id_rd_num !== 5'd5) begin
      n_fail++;
      $display("FAIL addi: v=%b imm=%h alu=%0d src=%b we=%b rs1=%h rd=%0d",
               id_valid, id_imm, id_alu_op, id_alu_src_imm, id_reg_we,
               id_rs1, id_rd_num);
    end
    tick();
    n_run++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_bubble: id_valid=%b want 0", id_valid);
    end
  endtask

  task automatic test_load_use;
    if_valid = 1; if_instr = 32'h00012303; if_pc = 32'h4;
    tick();
    if_instr = 32'h001303B3; if_pc = 32'h8;
    #1;
    n_run++;
    if (id_mem_re !== 1 || id_rs1 !== 32'h1000_0002 ||
        if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_stall: mre=%b rs1=%h rdy=%b want 1 10000002 0",
               id_mem_re, id_rs1, if_ready);
    end
    tick();
    n_run++;
    if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_bubble: v=%b rdy=%b want 0 1",
               id_valid, if_ready);
    end
    tick();
    if_valid = 0;
    n_run++;
    if (id_valid !== 1 || id_rd_num !== 5'd7 || id_rs1_num !== 5'd6 ||
        id_rs2 !== 32'h1000_0001 || id_pc !== 32'h8) begin
      n_fail++;
      $display("FAIL load_use_issue: v=%b rd=%0d rs1n=%0d rs2=%h pc=%h",
               id_valid, id_rd_num, id_rs1_num, id_rs2, id_pc);
    end
    tick();
  endtask

  task automatic test_hold;
    if_valid = 1; if_instr = 32'h002081B3; if_pc = 32'hC;
    tick();
    if_valid = 0; ex_ready = 0;
    n_run++;
    if (id_valid !== 1 || id_rs1 !== 32'h1000_0001) begin
      n_fail++;
      $display("FAIL hold_c1: v=%b rs1=%h want 1 10000001",
               id_valid, id_rs1);
    end
    tick();
    ma_wen = 1; ma_rd_num = 5'd1; ma_wdata = 32'hDEADBEEF;
    n_run++;
    if (id_valid !== 1 || id_rs1 !== 32'h1000_0001) begin
      n_fail++;
      $display("FAIL hold_c2: v=%b rs1=%h want 1 10000001",
               id_valid, id_rs1);
    end
    tick();
    ma_wen = 0;
    n_run++;
    if (id_valid !== 1 || id_rs1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL hold_c3: v=%b rs1=%h want 1 deadbeef",
               id_valid, id_rs1);
    end
    tick();
    ex_ready = 1;
    n_run++;
    if (id_valid !== 1 || id_rs1 !== 32'hDEADBEEF ||
        id_rs2 !== 32'h1000_0002) begin
      n_fail++;
      $display("FAIL hold_c4: v=%b rs1=%h rs2=%h want 1 deadbeef 10000002",
               id_valid, id_rs1, id_rs2);
    end
    tick();
    n_run++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drain: id_valid=%b want 0", id_valid);
    end
  endtask

  task automatic test_fresh_wb;
    if_valid = 1; if_instr = 32'h002081B3; if_pc = 32'h10;
    tick();
    if_valid = 0; ex_ready = 0;
    ma_wen = 1; ma_rd_num = 5'd2; ma_wdata = 32'h55;
    n_run++;
    if (id_rs2 !== 32'h1000_0002) begin
      n_fail++;
      $display("FAIL fresh_wb_pre: rs2=%h want 10000002", id_rs2);
    end
    tick();
    ma_wen = 0;
    n_run++;
    if (id_valid !== 1 || id_rs2 !== 32'h55) begin
      n_fail++;
      $display("FAIL fresh_wb_held: v=%b rs2=%h want 1 55", id_valid, id_rs2);
    end
    ex_ready = 1;
    tick();
  endtask

  task automatic test_flush;
    if_valid = 1; if_instr = 32'h00208463; if_pc = 32'h14;
    tick();
    n_run++;
    if (id_branch !== 1 || id_imm !== 32'd8 || id_valid !== 1) begin
      n_fail++;
      $display("FAIL flush_beq: br=%b imm=%h v=%b want 1 8 1",
               id_branch, id_imm, id_valid);
    end
    if_instr = 32'h00700293; if_pc = 32'h18; ex_flush = 1;
    #1;
    n_run++;
    if (if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: if_ready=%b want 0", if_ready);
    end
    tick();
    ex_flush = 0; if_valid = 0;
    n_run++;
    if (id_valid !== 0 || id_branch !== 0 || id_reg_we !== 0 ||
        id_alu_src_imm !== 0) begin
      n_fail++;
      $display("FAIL flush_kill: v=%b br=%b we=%b src=%b want 0 0 0 0",
               id_valid, id_branch, id_reg_we, id_alu_src_imm);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      if_valid = 1; if_instr = imm_ins[i]; if_pc = 32'h100 + 4 * i;
      tick();
      n_run++;
      if (id_valid !== 1 || id_imm !== imm_exp[i]) begin
        n_fail++;
        $display("FAIL imm_%0d: v=%b imm=%h want 1 %h",
                 i, id_valid, id_imm, imm_exp[i]);
      end
    end
    if_valid = 0;
    tick();
  endtask

  task automatic test_mul;
    if_valid = 1; if_instr = 32'h023100B3; if_pc = 32'h200;
    tick();
    if_valid = 0;
    n_run++;
`ifdef RIP_M_EXT_EN
    if (id_alu_op !== ALU_MUL || id_illegal !== 0 || id_reg_we !== 1) begin
      n_fail++;
      $display("FAIL mul: alu=%0d ill=%b we=%b want %0d 0 1",
               id_alu_op, id_illegal, id_reg_we, ALU_MUL);
    end
`else
    if (id_illegal !== 1 || id_reg_we !== 0 || id_valid !== 1) begin
      n_fail++;
      $display("FAIL mul: ill=%b we=%b v=%b want 1 0 1",
               id_illegal, id_reg_we, id_valid);
    end
`endif
    tick();
  endtask

  task automatic test_illegal;
    if_valid = 1; if_instr = 32'hFFFFFFFF; if_pc = 32'h204;
    tick();
    if_valid = 0;
    n_run++;
    if (id_illegal !== 1 || id_mem_we !== 0 || id_valid !== 1 ||
        id_reg_we !== 0 || id_mem_re !== 0) begin
      n_fail++;
      $display("FAIL illegal: ill=%b mwe=%b v=%b we=%b mre=%b",
               id_illegal, id_mem_we, id_valid, id_reg_we, id_mem_re);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_hold();
    test_fresh_wb();
    test_flush();
    test_back_to_back();
    test_mul();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
